// File: rtl/block_lock_fsm.sv
// 66b block lock acquisition/maintenance (Clause 49 style lock FSM).
// Watches qualified sync headers, declares lock after a clean window,
// drops lock on too many invalid headers per window, and issues slip
// pulses to the block-sync stage while hunting for alignment.
module block_lock_fsm #(
  parameter int HDR_WIDTH   = 2,
  parameter int SH_WINDOW   = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 4,   // 1..15, sized by the 4-bit wait counter
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [HDR_WIDTH-1:0] i_rx_sync_hdr,
  input  logic                 i_rx_sync_hdr_valid,
  output logic                 o_slip,
  output logic                 o_block_lock,
  output logic [CNT_WIDTH-1:0] o_slip_cnt
);

  localparam int SHC_W  = $clog2(SH_WINDOW) + 1;
  localparam int INV_W  = $clog2(INVALID_MAX) + 1;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_TEST_SH   = 2'd0,
    ST_SLIP      = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SHC_W-1:0]     sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]     sh_inv_q, sh_inv_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic                 slip_q, slip_d;
  logic                 lock_q, lock_d;
  logic [CNT_WIDTH-1:0] slip_cnt_q, slip_cnt_d;

  logic                 hdr_take;
  logic                 sh_ok;
  logic [SHC_W-1:0]     sh_cnt_n;
  logic [INV_W-1:0]     sh_inv_n;
  logic                 win_done;
  logic                 inv_limit;
  logic [CNT_WIDTH-1:0] slip_cnt_inc;

  // Header qualification; the raw header is masked by valid so an
  // unqualified (possibly X) header never reaches the counters.
  always_comb begin
    hdr_take  = i_rx_sync_hdr_valid && (state_q == ST_TEST_SH);
    sh_ok     = hdr_take &&
                ((i_rx_sync_hdr == HDR_WIDTH'(2'b01)) ||
                 (i_rx_sync_hdr == HDR_WIDTH'(2'b10)));
    sh_cnt_n  = sh_cnt_q + SHC_W'(1);
    sh_inv_n  = sh_inv_q + INV_W'(!sh_ok);
    win_done  = (sh_cnt_n == SHC_W'(SH_WINDOW));
    inv_limit = (sh_inv_n == INV_W'(INVALID_MAX));
    // Slip counter saturates at all-ones instead of wrapping.
    slip_cnt_inc = (&slip_cnt_q) ? slip_cnt_q : slip_cnt_q + CNT_WIDTH'(1);
  end

  // Next-state logic for the lock FSM, its counters and registered outputs.
  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    sh_inv_d   = sh_inv_q;
    wait_d     = wait_q;
    slip_d     = 1'b0;
    lock_d     = lock_q;
    slip_cnt_d = slip_cnt_q;

    unique case (state_q)
      ST_TEST_SH: begin
        if (hdr_take) begin
          if (!lock_q) begin
            if (!sh_ok) begin
              // Any bad header while hunting: try the next alignment.
              sh_cnt_d   = '0;
              sh_inv_d   = '0;
              state_d    = ST_SLIP;
              slip_d     = 1'b1;
              slip_cnt_d = slip_cnt_inc;
            end else if (win_done) begin
              // Full clean window; the next header starts a fresh window.
              lock_d   = 1'b1;
              sh_cnt_d = '0;
              sh_inv_d = '0;
            end else begin
              sh_cnt_d = sh_cnt_n;
              sh_inv_d = sh_inv_n;
            end
          end else begin
            // Invalid limit wins over a window rollover on the same header.
            if (inv_limit) begin
              lock_d     = 1'b0;
              sh_cnt_d   = '0;
              sh_inv_d   = '0;
              state_d    = ST_SLIP;
              slip_d     = 1'b1;
              slip_cnt_d = slip_cnt_inc;
            end else if (win_done) begin
              sh_cnt_d = '0;
              sh_inv_d = '0;
            end else begin
              sh_cnt_d = sh_cnt_n;
              sh_inv_d = sh_inv_n;
            end
          end
        end
      end

      ST_SLIP: begin
        // o_slip is high during this cycle; arm the realign holdoff.
        wait_d  = WAIT_W'(SLIP_WAIT - 1);
        state_d = ST_SLIP_WAIT;
      end

      ST_SLIP_WAIT: begin
        // Gearbox is realigning; headers in this window are meaningless.
        if (wait_q == '0) begin
          state_d  = ST_TEST_SH;
          sh_cnt_d = '0;
          sh_inv_d = '0;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      default: begin
        state_d  = ST_TEST_SH;
        sh_cnt_d = '0;
        sh_inv_d = '0;
        wait_d   = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything including a pulse in flight.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_TEST_SH;
      sh_cnt_q   <= '0;
      sh_inv_q   <= '0;
      wait_q     <= '0;
      slip_q     <= 1'b0;
      lock_q     <= 1'b0;
      slip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_cnt_q   <= sh_cnt_d;
      sh_inv_q   <= sh_inv_d;
      wait_q     <= wait_d;
      slip_q     <= slip_d;
      lock_q     <= lock_d;
      slip_cnt_q <= slip_cnt_d;
    end
  end

  assign o_slip       = slip_q;
  assign o_block_lock = lock_q;
  assign o_slip_cnt   = slip_cnt_q;

endmodule

// File: tb/tb_block_lock_fsm.sv
// Directed, table-driven bench for block_lock_fsm. A second instance with a
// 2-bit slip counter exercises saturation without forcing internal state.
module tb_block_lock_fsm;

  logic        clk;
  logic        rst_n;
  logic [1:0]  hdr;
  logic        vld;
  logic        slip, lock;
  logic [15:0] cnt;
  logic        slip2, lock2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  block_lock_fsm dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_rx_sync_hdr(hdr),
    .i_rx_sync_hdr_valid(vld), .o_slip(slip), .o_block_lock(lock),
    .o_slip_cnt(cnt)
  );

  block_lock_fsm #(.CNT_WIDTH(2)) dut_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_rx_sync_hdr(hdr),
    .i_rx_sync_hdr_valid(vld), .o_slip(slip2), .o_block_lock(lock2),
    .o_slip_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  hdr;
    logic        vld;
    logic        slip;
    logic        lock;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [1:0] h, logic v, logic s, logic l, logic [15:0] c);
    vec_t e;
    e.hdr = h; e.vld = v; e.slip = s; e.lock = l; e.cnt = c;
    tbl.push_back(e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One header per clock: drive, take the edge, sample 1 time unit later.
  task automatic step(logic [1:0] h, logic v);
    hdr = h; vld = v;
    @(posedge clk); #1;
  endtask

  task automatic run_table(string tag);
    foreach (tbl[i]) begin
      step(tbl[i].hdr, tbl[i].vld);
      chk($sformatf("%s[%0d].slip", tag, i), {31'd0, slip}, {31'd0, tbl[i].slip});
      chk($sformatf("%s[%0d].lock", tag, i), {31'd0, lock}, {31'd0, tbl[i].lock});
      chk($sformatf("%s[%0d].cnt",  tag, i), {16'd0, cnt},  {16'd0, tbl[i].cnt});
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vld = 1'b0; hdr = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [1:0] good(int i);
    return (i % 2 == 1) ? 2'b10 : 2'b01;
  endfunction

  // 64 clean headers every cycle; lock rises right after the 64th.
  function automatic void add_acquire(logic [15:0] c);
    for (int i = 1; i <= 64; i++) add(good(i), 1'b1, 1'b0, (i == 64), c);
  endfunction

  initial begin
    int last_pulse;
    int pulses;
    rst_n = 1'b0; hdr = 2'b00; vld = 1'b0;

    // Reset held with random inputs: outputs stay cleared.
    for (int i = 0; i < 10; i++) begin
      hdr = 2'($urandom_range(0, 3)); vld = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk($sformatf("rst[%0d].slip", i), {31'd0, slip}, 32'd0);
      chk($sformatf("rst[%0d].lock", i), {31'd0, lock}, 32'd0);
      chk($sformatf("rst[%0d].cnt",  i), {16'd0, cnt},  32'd0);
    end
    vld = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    #1 chk("rst_release.slip", {31'd0, slip}, 32'd0);
    step(2'b00, 1'b0);
    chk("post_rst.slip", {31'd0, slip}, 32'd0);
    chk("post_rst.lock", {31'd0, lock}, 32'd0);

    // Acquire with valid every cycle.
    add_acquire(16'd0);
    run_table("acq1");

    // Acquire with valid every third cycle; idle cycles carry a bad header.
    do_reset();
    for (int q = 1; q <= 64; q++) begin
      add(2'b00, 1'b0, 1'b0, 1'b0, 16'd0);
      add(2'b11, 1'b0, 1'b0, 1'b0, 16'd0);
      add(good(q), 1'b1, 1'b0, (q == 64), 16'd0);
    end
    run_table("acq3");

    // Unlocked slip: 9 good, bad 10th, slip next edge for one cycle.
    do_reset();
    for (int i = 1; i <= 9; i++) add(good(i), 1'b1, 1'b0, 1'b0, 16'd0);
    add(2'b00, 1'b1, 1'b1, 1'b0, 16'd1);
    add(2'b01, 1'b1, 1'b0, 1'b0, 16'd1);                 // SLIP cycle
    for (int i = 0; i < 4; i++) add(2'b00, 1'b1, 1'b0, 1'b0, 16'd1); // ignored
    add_acquire(16'd1);                                   // restart from 0
    run_table("uslip");

    // Locked: 15 invalid in a window is tolerated.
    for (int i = 0; i < 64; i++)
      add((i % 4 == 0 && i < 60) ? 2'b11 : good(i), 1'b1, 1'b0, 1'b1, 16'd1);
    // Next window: 16th invalid (at header 61) drops lock and slips.
    for (int i = 0; i <= 60; i++)
      add((i % 4 == 0) ? 2'b11 : good(i), 1'b1, (i == 60), (i != 60),
          (i == 60) ? 16'd2 : 16'd1);
    add(2'b01, 1'b1, 1'b0, 1'b0, 16'd2);
    run_table("ltol");

    // Boundary: 16th invalid is also the 64th header of the window.
    do_reset();
    add_acquire(16'd0);
    for (int i = 0; i < 64; i++)
      add((i >= 48) ? 2'b11 : good(i), 1'b1, (i == 63), (i != 63),
          (i == 63) ? 16'd1 : 16'd0);
    run_table("bnd");

    // Slip storm: pulses every SLIP_WAIT+2 = 6 cycles, first right away.
    do_reset();
    last_pulse = 0; pulses = 0;
    for (int s = 1; s <= 1000; s++) begin
      step(2'b00, 1'b1);
      chk($sformatf("storm[%0d].slip", s), {31'd0, slip}, {31'd0, ((s - 1) % 6 == 0)});
      if (slip) begin
        pulses++;
        if (last_pulse != 0)
          chk($sformatf("storm[%0d].gap", s), s - last_pulse, 32'd6);
        last_pulse = s;
      end
    end
    chk("storm.pulses", pulses, 32'd167);
    chk("storm.cnt", {16'd0, cnt}, 32'd167);
    chk("storm.lock", {31'd0, lock}, 32'd0);
    chk("storm.sat_cnt", {30'd0, cnt2}, 32'd3);

    // Now mid-SLIP_WAIT (last pulse at 997): async reset clears at once.
    #2 rst_n = 1'b0;
    #1;
    chk("amid.cnt", {16'd0, cnt}, 32'd0);
    chk("amid.sat_cnt", {30'd0, cnt2}, 32'd0);
    chk("amid.slip", {31'd0, slip}, 32'd0);
    chk("amid.lock", {31'd0, lock}, 32'd0);
    vld = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    // Back in TEST_SH immediately: a bad header slips on the next edge.
    step(2'b00, 1'b1);
    chk("amid_resume.slip", {31'd0, slip}, 32'd1);
    chk("amid_resume.cnt", {16'd0, cnt}, 32'd1);
    chk("amid_resume.sat_slip", {31'd0, slip2}, 32'd1);
    chk("amid_resume.sat_lock", {31'd0, lock2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/block_lock_fsm.md
Name: block_lock_fsm

Overview:
- Consumes the 2-bit sync header stream from the RX gearbox/block-sync stage and acquires and maintains 66b block lock, per the IEEE 802.3 Clause 49 lock state machine.
- While unlocked or after losing lock, issues single-cycle slip pulses back to the block-sync stage, shifting its header alignment until a stable position is found.
- `o_block_lock` feeds the downstream descrambler/decoder and the BER monitor.

Parameters:
- HDR_WIDTH, 2, sync header width.
- SH_WINDOW, 64, headers per test window.
- INVALID_MAX, 16, invalid headers in one window that drop lock.
- SLIP_WAIT, 4, clock cycles ignored after a slip pulse while the gearbox realigns; legal range 1..15.
- CNT_WIDTH, 16, width of the slip event counter.

Ports:
- i_clk  in  1  Clock. One clock domain; all logic is on its rising edge.
- i_reset_n  in  1  Reset. Asynchronous assert, active-low.
- i_rx_sync_hdr  in  HDR_WIDTH  Sync header from the block-sync stage.
- i_rx_sync_hdr_valid  in  1  Qualifies i_rx_sync_hdr. High exactly once per 66b block.
- o_slip  out  1  One-cycle slip request to the block-sync stage's i_slip.
- o_block_lock  out  1  Block lock achieved.
- o_slip_cnt  out  CNT_WIDTH  Saturating count of slip pulses issued since reset.

Behaviour:
- Reset values (asynchronous, i_reset_n=0):
  - o_slip=0, o_block_lock=0, o_slip_cnt=0.
  - sh_cnt=0, sh_invalid_cnt=0, wait_cnt=0.
  - state=TEST_SH.
- Header validity: sh_ok = (hdr==2'b01) || (hdr==2'b10). Values 2'b00 and 2'b11 are invalid.
- Counters:
  - sh_cnt is $clog2(SH_WINDOW)+1 bits.
  - sh_invalid_cnt is $clog2(INVALID_MAX)+1 bits.
  - Both advance only on cycles where i_rx_sync_hdr_valid=1 and state=TEST_SH.
  - Cycles with valid low do not count. Gaps of any length are legal.
- States: TEST_SH, SLIP, SLIP_WAIT.
- TEST_SH, each qualified header (sh_cnt_n = sh_cnt+1, inv_n = sh_invalid_cnt + !sh_ok):
  - Unlocked (o_block_lock=0), invalid header: clear both counters, go to SLIP.
  - Unlocked, sh_cnt_n==SH_WINDOW with inv_n==0: set o_block_lock=1, clear counters, stay in TEST_SH. No header is lost at the window boundary.
  - Locked, inv_n==INVALID_MAX: clear o_block_lock, clear counters, go to SLIP. This check takes priority over window completion on the same header.
  - Locked, sh_cnt_n==SH_WINDOW with inv_n<INVALID_MAX: clear counters, stay locked, stay in TEST_SH.
  - Otherwise: sh_cnt<=sh_cnt_n, sh_invalid_cnt<=inv_n.
- SLIP:
  - o_slip=1 for exactly this one cycle. o_slip is registered and high the cycle after the triggering header.
  - o_slip_cnt increments, saturating at all-ones.
  - Load wait_cnt=SLIP_WAIT-1, go to SLIP_WAIT.
- SLIP_WAIT:
  - Headers are ignored.
  - wait_cnt decrements each clock. When wait_cnt==0, go to TEST_SH with counters cleared.
- Slip spacing: consecutive slip pulses are at least SLIP_WAIT+2 cycles apart. Slip is never asserted on back-to-back cycles.
- o_block_lock timing: changes only on the clock edge after the deciding header. It never changes outside TEST_SH transitions.
- Latency:
  - Header to o_slip: 1 cycle.
  - 64th good header to o_block_lock rise: 1 cycle.
- Reset mid-operation: asynchronous clear of all state and outputs, including a pulse in flight. Normal operation resumes on the first clock edge after deassertion.
- Header inputs are don't-care while i_rx_sync_hdr_valid=0. X on an unqualified header must not propagate into state.

Test Plan:
- Reset: hold i_reset_n=0 with random inputs -> o_slip=0, o_block_lock=0, o_slip_cnt=0 throughout. Deassert reset mid-cycle -> no glitch on o_slip.
- Acquire: 64 qualified headers alternating 2'b01/2'b10, valid high every cycle -> o_block_lock rises 1 cycle after the 64th header, o_slip never asserted. Repeat with valid high every 3rd cycle -> same result after the 64th qualified header.
- Unlocked slip: 9 good headers then 2'b00 on the 10th -> o_slip high 1 cycle later for exactly 1 cycle, o_slip_cnt=1. Next 4 headers (SLIP_WAIT=4) are ignored even if invalid. Counting restarts at 0 and lock needs 64 further good headers.
- Locked tolerance: after lock, a window with 15 invalid headers (2'b11) spread among 64 -> lock held, no slip. Next window with 16 invalid -> o_block_lock falls and o_slip pulses 1 cycle after the 16th invalid header.
- Boundary priority: locked, 16th invalid header is also the 64th header of the window -> lock drops and slip is issued, not a window rollover.
- Slip storm: constant 2'b00 headers for 1000 cycles -> slip pulses exactly SLIP_WAIT+2 cycles apart, o_slip_cnt matches pulse count. Force o_slip_cnt to 16'hFFFE -> it saturates at 16'hFFFF. Async reset mid-SLIP_WAIT -> everything returns to reset values immediately.
